// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: decoupled imem request/response with an in-order prefetch FIFO
// feeding a freeze/flush output register toward ID. Optional IF_PREFETCH_BYPASS_EN skips the FIFO when empty.
module if_prefetch_stage #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 4,
    parameter int PC_STEP = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               flush,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [INSTR_W-1:0] instruction_out,
    output logic               valid_out
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);
    localparam logic [CNT_W-1:0]  ONE     = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d, drop_q, drop_d, count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]  fifo_pc_q [DEPTH];
    logic [ADDR_W-1:0]  fifo_pc_d [DEPTH];
    logic [INSTR_W-1:0] fifo_ins_q [DEPTH];
    logic [INSTR_W-1:0] fifo_ins_d [DEPTH];
    logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;

    logic               grant, push, push_fifo, pop, bypass;
    logic [CNT_W:0]     occupancy;
    logic [ADDR_W-1:0]  resp_next_pc;

    always_comb begin
        occupancy    = {1'b0, count_q} + {1'b0, inflight_q};
        imem_req     = !rst && !branch_taken && (occupancy < DEPTH_C);
        grant        = imem_req && imem_gnt;
        push         = imem_rvalid && (drop_q == '0) && !branch_taken;
        pop          = !flush && !freeze && !branch_taken && (count_q != '0);
        resp_next_pc = resp_pc_q + STEP;
`ifdef IF_PREFETCH_BYPASS_EN
        bypass       = push && (count_q == '0) && !freeze && !flush;
`else
        bypass       = 1'b0;
`endif
        push_fifo    = push && !bypass;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_pc_d  = fifo_pc_q;
        fifo_ins_d = fifo_ins_q;

        if (grant) begin
            fetch_pc_d = fetch_pc_q + STEP;
            inflight_d = inflight_d + ONE;
        end
        // Saturate so a response with nothing outstanding cannot wrap the counter.
        if (imem_rvalid && (inflight_q != '0)) begin
            inflight_d = inflight_d - ONE;
        end
        if (imem_rvalid && (drop_q != '0)) begin
            drop_d = drop_q - ONE;
        end
        if (push) begin
            resp_pc_d = resp_next_pc;
        end
        if (push_fifo) begin
            fifo_pc_d[wr_ptr_q]  = resp_next_pc;
            fifo_ins_d[wr_ptr_q] = imem_rdata;
            wr_ptr_d             = wr_ptr_q + PTR_ONE;
            count_d              = count_d + ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            count_d  = count_d - ONE;
        end

        // Every response still outstanding after this cycle is stale, including ones
        // already marked for dropping, so drop tracks the remaining in-flight count.
        if (branch_taken) begin
            fetch_pc_d = branch_addr;
            resp_pc_d  = branch_addr;
            drop_d     = inflight_d;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    always_comb begin
        pc_out_d = '0;
        instr_d  = '0;
        valid_d  = 1'b0;
        if (flush) begin
            valid_d = 1'b0;
        end else if (freeze) begin
            pc_out_d = pc_out_q;
            instr_d  = instr_q;
            valid_d  = valid_q;
        end else if (pop) begin
            pc_out_d = fifo_pc_q[rd_ptr_q];
            instr_d  = fifo_ins_q[rd_ptr_q];
            valid_d  = 1'b1;
        end else if (bypass) begin
            pc_out_d = resp_next_pc;
            instr_d  = imem_rdata;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= '0;
            resp_pc_q  <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pc_out_q   <= '0;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]  <= '0;
                fifo_ins_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pc_out_q   <= pc_out_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            fifo_pc_q  <= fifo_pc_d;
            fifo_ins_q <= fifo_ins_d;
        end
    end

    assign imem_addr       = fetch_pc_q;
    assign pc_out          = pc_out_q;
    assign instruction_out = instr_q;
    assign valid_out       = valid_q;

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage (default build): in-order memory model with
// configurable response latency, rdata = request address.
module tb_if_prefetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;

    if_prefetch_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .branch_taken(branch_taken), .branch_addr(branch_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc_out(pc_out), .instruction_out(instruction_out), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mem_q[$];
    int          cyc = 0;
    int          lat = 1;
    logic        spur = 1'b0;
    logic [31:0] spur_data = '0;
    logic        last_req;
    logic [31:0] last_addr;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: present this cycle's response, record any grant, then advance.
    task automatic tick();
        if (rst) mem_q.delete();
        if (spur) begin
            imem_rvalid = 1'b1;
            imem_rdata  = spur_data;
        end else if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_q[0].addr;
            void'(mem_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        #1;
        last_req  = imem_req;
        last_addr = imem_addr;
        if (!rst && imem_req && imem_gnt) mem_q.push_back('{imem_addr, cyc + lat});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; freeze = 1'b0; flush = 1'b0; branch_taken = 1'b0;
        imem_gnt = 1'b0; spur = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [31:0] e_pc, e_in;
        logic        e_v, e_req;

        // Reset, streaming, 6-cycle freeze, then full-FIFO push+pop with a spurious response.
        lat = 1;
        do_reset();
        check("rst_req", {31'b0, last_req}, 32'd0);
        check("rst_pc", pc_out, 32'd0);
        check("rst_instr", instruction_out, 32'd0);
        check("rst_valid", {31'b0, valid_out}, 32'd0);
        spur_data = 32'hDEAD_BEEF;
        for (int c = 0; c < 18; c++) begin
            freeze   = (c >= 6 && c <= 11);
            imem_gnt = (c < 12);
            spur     = (c == 12);
            tick();
            e_pc  = (c < 2) ? 32'd0 : (c <= 5) ? 32'(4 * (c - 1)) :
                    (c <= 11) ? 32'd16 : (c <= 16) ? 32'(20 + 4 * (c - 12)) : 32'd0;
            e_v   = (c >= 2 && c <= 16);
            e_in  = !e_v ? 32'd0 : (c == 16) ? 32'hDEAD_BEEF : e_pc - 32'd4;
            e_req = (c <= 7) || (c >= 14);
            check($sformatf("a_req%0d", c), {31'b0, last_req}, {31'b0, e_req});
            if (e_req) check($sformatf("a_addr%0d", c), last_addr, (c <= 7) ? 32'(4 * c) : 32'd32);
            check($sformatf("a_pc%0d", c), pc_out, e_pc);
            check($sformatf("a_instr%0d", c), instruction_out, e_in);
            check($sformatf("a_valid%0d", c), {31'b0, valid_out}, {31'b0, e_v});
        end
        spur = 1'b0;

        // Redirect with flush while three late responses are outstanding.
        lat = 4;
        do_reset();
        imem_gnt = 1'b1;
        tick(); tick(); tick();
        branch_taken = 1'b1; flush = 1'b1; branch_addr = 32'h100;
        tick();
        check("c_req_br", {31'b0, last_req}, 32'd0);
        check("c_valid_br", {31'b0, valid_out}, 32'd0);
        branch_taken = 1'b0; flush = 1'b0;
        n = 0;
        while (!valid_out && n < 20) begin tick(); n++; end
        check("c_lat", 32'(n), 32'd6);
        check("c_pc0", pc_out, 32'h104);
        check("c_instr0", instruction_out, 32'h100);
        tick();
        check("c_pc1", pc_out, 32'h108);
        check("c_instr1", instruction_out, 32'h104);

        // Response arriving in the same cycle as the redirect is dropped.
        lat = 2;
        do_reset();
        imem_gnt = 1'b1;
        tick(); tick();
        branch_taken = 1'b1; branch_addr = 32'h200;
        tick();
        check("d_req_br", {31'b0, last_req}, 32'd0);
        branch_taken = 1'b0;
        n = 0;
        while (!valid_out && n < 20) begin tick(); n++; end
        check("d_lat", 32'(n), 32'd4);
        check("d_pc0", pc_out, 32'h204);
        check("d_instr0", instruction_out, 32'h200);
        tick();
        check("d_pc1", pc_out, 32'h208);
        check("d_instr1", instruction_out, 32'h204);

        // Address wrap-around, then reset mid-stream.
        lat = 1;
        do_reset();
        imem_gnt = 1'b1;
        branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
        tick();
        check("e_req_br", {31'b0, last_req}, 32'd0);
        branch_taken = 1'b0;
        tick();
        check("e_addr0", last_addr, 32'hFFFF_FFFC);
        tick();
        check("e_addr1", last_addr, 32'h0);
        tick();
        check("e_pc0", pc_out, 32'h0);
        check("e_instr0", instruction_out, 32'hFFFF_FFFC);
        check("e_valid0", {31'b0, valid_out}, 32'd1);
        tick();
        check("e_pc1", pc_out, 32'h4);
        check("e_instr1", instruction_out, 32'h0);
        rst = 1'b1;
        tick();
        check("e_rst_req", {31'b0, last_req}, 32'd0);
        check("e_rst_pc", pc_out, 32'd0);
        check("e_rst_valid", {31'b0, valid_out}, 32'd0);
        rst = 1'b0;
        tick();
        check("e_post_rst_addr", last_addr, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
